branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 149 ++++++++++++++
 tb/tb_branch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: decodes branch opcodes, forwards live ALU flags,
// squashes the younger instruction after a taken branch and keeps branch statistics.

package definitions;
    localparam logic [3:0] kBRC = 4'hC;
    localparam logic [3:0] kBRR = 4'hD;
    localparam logic [3:0] kBRO = 4'hE;
endpackage

// state    | meaning
// ST_IDLE  | branches are evaluated, counted and may be taken
// ST_FLUSH | younger instruction squashed; branches ignored until fcnt reaches 0
module branch_ctrl #(
    parameter int IW        = 9,
    parameter int OPW       = 4,
    parameter int FLUSH_CYC = 1,
    parameter int CNTW      = 16,
    parameter logic [OPW-1:0] OP_BRC = definitions::kBRC,
    parameter logic [OPW-1:0] OP_BRR = definitions::kBRR,
    parameter logic [OPW-1:0] OP_BRO = definitions::kBRO
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [IW-1:0]   Instruction,
    input  logic            instr_valid,
    input  logic            ZERO,
    input  logic            CARRY,
    input  logic            OVF,
    input  logic            flag_we,
    input  logic            clr_cnt,
    output logic            branch_en,
    output logic            flush,
    output logic [CNTW-1:0] taken_cnt,
    output logic [CNTW-1:0] ntaken_cnt,
    output logic [2:0]      flags_q
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYC - 1);

    state_t          state, state_nxt;
    logic [1:0]      fcnt, fcnt_nxt;
    logic [OPW-1:0]  opcode;
    logic [1:0]      cond;
    logic [2:0]      eff;
    logic            op_brc, op_brr, op_bro;
    logic            is_br;
    logic            cond_true;
    logic            taken_inc, ntaken_inc;
    logic            unused_instr;

    assign opcode       = Instruction[IW-1 -: OPW];
    assign cond         = Instruction[1:0];
    assign unused_instr = ^Instruction[IW-OPW-1:2];

    // Same-cycle flag producer is forwarded so a dependent branch needs no stall.
    assign eff = flag_we ? {OVF, CARRY, ZERO} : flags_q;

    always_comb begin
        op_brc    = (opcode == OP_BRC);
        op_brr    = (opcode == OP_BRR);
        op_bro    = (opcode == OP_BRO);
        is_br     = instr_valid & (op_brc | op_brr | op_bro);
        cond_true = 1'b0;
        if (op_brc) begin
            case (cond)
                2'b00:   cond_true = 1'b1;
                2'b01:   cond_true = eff[0];
                2'b10:   cond_true = ~eff[0];
                default: cond_true = eff[1];
            endcase
        end else if (op_brr) begin
            cond_true = 1'b1;
        end else if (op_bro) begin
            cond_true = eff[2];
        end
    end

    assign branch_en  = is_br & cond_true & (state == ST_IDLE);
    assign taken_inc  = branch_en;
    assign ntaken_inc = is_br & ~branch_en & (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        flush     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (branch_en) begin
                    state_nxt = ST_FLUSH;
                    fcnt_nxt  = FCNT_LOAD;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (fcnt == 2'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    fcnt_nxt = fcnt - 2'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                fcnt_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            fcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flags_q <= 3'b000;
        end else if (flag_we) begin
            flags_q <= {OVF, CARRY, ZERO};
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else if (clr_cnt) begin
            taken_cnt  <= '0;
            ntaken_cnt <= '0;
        end else begin
            if (taken_inc && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNTW'(1);
            end
            if (ntaken_inc && (ntaken_cnt != '1)) begin
                ntaken_cnt <= ntaken_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed scoreboard bench for branch_ctrl with FLUSH_CYC=3 and CNTW=4.

module tb_branch_ctrl;

    localparam int S_BE = 0;
    localparam int S_FL = 1;
    localparam int S_FQ = 2;
    localparam int S_TK = 3;
    localparam int S_NT = 4;

    logic       Clk;
    logic       Reset_n;
    logic [8:0] Instruction;
    logic       instr_valid;
    logic       ZERO, CARRY, OVF;
    logic       flag_we;
    logic       clr_cnt;
    logic       branch_en;
    logic       flush;
    logic [3:0] taken_cnt;
    logic [3:0] ntaken_cnt;
    logic [2:0] flags_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    branch_ctrl #(.FLUSH_CYC(3), .CNTW(4)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Instruction(Instruction),
        .instr_valid(instr_valid),
        .ZERO(ZERO),
        .CARRY(CARRY),
        .OVF(OVF),
        .flag_we(flag_we),
        .clr_cnt(clr_cnt),
        .branch_en(branch_en),
        .flush(flush),
        .taken_cnt(taken_cnt),
        .ntaken_cnt(ntaken_cnt),
        .flags_q(flags_q)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_BE:    return 32'(branch_en);
            S_FL:    return 32'(flush);
            S_FQ:    return 32'(flags_q);
            S_TK:    return 32'(taken_cnt);
            default: return 32'(ntaken_cnt);
        endcase
    endfunction

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // vcz = {OVF, CARRY, ZERO}
    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] cond,
                         input logic fwe, input logic [2:0] vcz, input logic clr);
        instr_valid = v;
        Instruction = {op, 3'b000, cond};
        flag_we     = fwe;
        OVF         = vcz[2];
        CARRY       = vcz[1];
        ZERO        = vcz[0];
        clr_cnt     = clr;
    endtask

    task automatic step();
        #1;
        check_sb();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b0);
        #2;
        expect_v("rst_flush", S_FL, 0);
        expect_v("rst_flags", S_FQ, 0);
        expect_v("rst_taken", S_TK, 0);
        expect_v("rst_ntaken", S_NT, 0);
        check_sb();
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        #1;
        expect_v("rst_be_brr", S_BE, 1);
        check_sb();
        drive(1'b1, definitions::kBRC, 2'b01, 1'b0, 3'b000, 1'b0);
        #1;
        expect_v("rst_be_brc_z0", S_BE, 0);
        check_sb();
        drive(1'b1, definitions::kBRC, 2'b01, 1'b1, 3'b001, 1'b0);
        #1;
        expect_v("rst_be_fwd", S_BE, 1);
        check_sb();
        @(posedge Clk);
        #1;
        expect_v("rst_hold_flags", S_FQ, 0);
        expect_v("rst_hold_flush", S_FL, 0);
        expect_v("rst_hold_taken", S_TK, 0);
        check_sb();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b0);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // forwarding of a same-cycle flag producer
        drive(1'b1, definitions::kBRC, 2'b01, 1'b1, 3'b001, 1'b0);
        expect_v("fwd_be", S_BE, 1);
        expect_v("fwd_flush_pre", S_FL, 0);
        step();
        expect_v("fwd_flags", S_FQ, 3'b001);
        expect_v("fwd_flush", S_FL, 1);
        expect_v("fwd_taken", S_TK, 1);
        expect_v("fwd_ntaken", S_NT, 0);
        idle_steps(3);
        expect_v("fwd_flush_end", S_FL, 0);

        // stored flags, cond 10
        drive(1'b0, 4'h0, 2'b00, 1'b1, 3'b000, 1'b1);
        step();
        expect_v("st_flags0", S_FQ, 0);
        expect_v("st_clr", S_TK, 0);
        drive(1'b1, definitions::kBRC, 2'b10, 1'b0, 3'b000, 1'b0);
        expect_v("st_be", S_BE, 1);
        step();
        expect_v("st_flush", S_FL, 1);
        expect_v("st_taken", S_TK, 1);
        idle_steps(3);
        expect_v("st_flush_end", S_FL, 0);

        // flush window: branches in FLUSH are ignored, flag writes still land
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b1);
        step();
        expect_v("fw_clr", S_TK, 0);
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("fw_be0", S_BE, 1);
        step();
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("fw_be1", S_BE, 0);
        expect_v("fw_fl1", S_FL, 1);
        step();
        drive(1'b1, definitions::kBRR, 2'b00, 1'b1, 3'b100, 1'b0);
        expect_v("fw_be2", S_BE, 0);
        expect_v("fw_fl2", S_FL, 1);
        expect_v("fw_fq2", S_FQ, 0);
        step();
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("fw_be3", S_BE, 0);
        expect_v("fw_fl3", S_FL, 1);
        expect_v("fw_fq3", S_FQ, 3'b100);
        step();
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("fw_fl_end", S_FL, 0);
        expect_v("fw_taken", S_TK, 1);
        expect_v("fw_ntaken", S_NT, 0);
        step();

        // not-taken and condition coverage
        drive(1'b0, 4'h0, 2'b00, 1'b1, 3'b000, 1'b1);
        step();
        expect_v("nt_flags0", S_FQ, 0);
        drive(1'b1, definitions::kBRO, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("nt_bro_be", S_BE, 0);
        step();
        expect_v("nt_bro_flush", S_FL, 0);
        expect_v("nt_bro_ntaken", S_NT, 1);
        expect_v("nt_bro_taken", S_TK, 0);
        drive(1'b1, 4'h3, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("nb_be", S_BE, 0);
        step();
        expect_v("nb_ntaken", S_NT, 1);
        expect_v("nb_taken", S_TK, 0);
        expect_v("nb_flush", S_FL, 0);
        drive(1'b1, definitions::kBRC, 2'b01, 1'b0, 3'b000, 1'b0);
        expect_v("c01_be", S_BE, 0);
        step();
        expect_v("c01_ntaken", S_NT, 2);
        drive(1'b1, definitions::kBRC, 2'b11, 1'b1, 3'b010, 1'b0);
        expect_v("c11_be", S_BE, 1);
        step();
        expect_v("c11_flush", S_FL, 1);
        expect_v("c11_taken", S_TK, 1);
        expect_v("c11_flags", S_FQ, 3'b010);
        idle_steps(3);
        drive(1'b1, definitions::kBRO, 2'b00, 1'b1, 3'b100, 1'b0);
        expect_v("bro_fwd_be", S_BE, 1);
        step();
        expect_v("bro_fwd_taken", S_TK, 2);
        expect_v("bro_fwd_flags", S_FQ, 3'b100);
        expect_v("bro_fwd_flush", S_FL, 1);
        idle_steps(3);
        drive(1'b0, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("inval_be", S_BE, 0);
        step();
        expect_v("inval_taken", S_TK, 2);
        expect_v("inval_ntaken", S_NT, 2);
        expect_v("inval_flush", S_FL, 0);
        drive(1'b1, definitions::kBRC, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("c00_be", S_BE, 1);
        step();
        expect_v("c00_taken", S_TK, 3);
        idle_steps(3);
        drive(1'b1, definitions::kBRC, 2'b10, 1'b1, 3'b001, 1'b0);
        expect_v("c10_z1_be", S_BE, 0);
        step();
        expect_v("c10_z1_ntaken", S_NT, 3);
        expect_v("c10_z1_flags", S_FQ, 3'b001);
        drive(1'b1, definitions::kBRC, 2'b11, 1'b0, 3'b000, 1'b0);
        expect_v("c11_c0_be", S_BE, 0);
        step();
        expect_v("c11_c0_ntaken", S_NT, 4);

        // saturation and clear priority
        drive(1'b0, 4'h0, 2'b00, 1'b1, 3'b000, 1'b1);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
            step();
            idle_steps(3);
        end
        expect_v("sat_taken", S_TK, 15);
        expect_v("sat_taken_nt", S_NT, 0);
        expect_v("sat_flush", S_FL, 0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, definitions::kBRO, 2'b00, 1'b0, 3'b000, 1'b0);
            step();
        end
        drive(1'b0, 4'h0, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("sat_ntaken", S_NT, 15);
        expect_v("sat_ntaken_tk", S_TK, 15);
        step();
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b1);
        expect_v("clr_be", S_BE, 1);
        step();
        expect_v("clr_taken", S_TK, 0);
        expect_v("clr_ntaken", S_NT, 0);
        expect_v("clr_flush", S_FL, 1);
        idle_steps(3);

        // reset during the second flush cycle
        drive(1'b1, definitions::kBRR, 2'b00, 1'b1, 3'b010, 1'b0);
        expect_v("rmf_be", S_BE, 1);
        step();
        expect_v("rmf_fl1", S_FL, 1);
        expect_v("rmf_tk1", S_TK, 1);
        expect_v("rmf_fq1", S_FQ, 3'b010);
        idle_steps(1);
        expect_v("rmf_fl2", S_FL, 1);
        check_sb();
        Reset_n = 1'b0;
        #1;
        expect_v("rmf_rst_flush", S_FL, 0);
        expect_v("rmf_rst_taken", S_TK, 0);
        expect_v("rmf_rst_ntaken", S_NT, 0);
        expect_v("rmf_rst_flags", S_FQ, 0);
        check_sb();
        @(posedge Clk);
        #1;
        expect_v("rmf_rst_hold", S_FL, 0);
        check_sb();
        #3;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        drive(1'b1, definitions::kBRR, 2'b00, 1'b0, 3'b000, 1'b0);
        expect_v("rmf_post_be", S_BE, 1);
        expect_v("rmf_post_fl0", S_FL, 0);
        step();
        expect_v("rmf_post_flush", S_FL, 1);
        expect_v("rmf_post_taken", S_TK, 1);
        idle_steps(3);
        expect_v("rmf_post_end", S_FL, 0);
        step();
        check_sb();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
